rename_dispatch_queue: RTL

RENAME_DISPATCH_QUEUE -- requirements
Module: rename_dispatch_queue

---
 rtl/rename_dispatch_queue_pkg.sv | 24 ++
 rtl/rename_dispatch_queue_if.sv | 26 ++
 rtl/rename_dispatch_queue_rdq_ptr_adv.sv | 22 ++
 rtl/rename_dispatch_queue.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rename_dispatch_queue_pkg.sv
// Shared types and defaults for the rename-to-dispatch queue.
package rename_dispatch_queue_pkg;

  localparam int unsigned RD_QUEUE_WIDTH = 2;
  localparam int unsigned RD_QUEUE_DEPTH = 8;

  typedef enum logic [2:0] {
    FU_ALU, FU_MUL, FU_DIV, FU_LD, FU_ST, FU_BR, FU_FPU, FU_CSR
  } fu_e;

  typedef struct packed {
    logic [7:0] opcode;
    fu_e        fu;
    logic [6:0] pdst;
    logic [6:0] psrc1;
    logic [6:0] psrc2;
  } Disp_uOP;

  // Valid lanes must form a run starting at lane 0 (0..01..1).
  function automatic logic lanes_contiguous(input logic [31:0] v);
    return (v & (v + 32'd1)) == '0;
  endfunction

endpackage

// File: rtl/rename_dispatch_queue_if.sv
// Rename/dispatch handshake bundle; master = rename+dispatch, slave = queue.
interface rename_dispatch_queue_if
  import rename_dispatch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = RD_QUEUE_WIDTH,
  parameter int unsigned DEPTH = RD_QUEUE_DEPTH
);
  logic                           flush;
  Disp_uOP [WIDTH-1:0]            enq_uop;
  logic [WIDTH-1:0]               enq_valid;
  logic                           enq_ready;
  Disp_uOP [WIDTH-1:0]            deq_uop;
  logic [WIDTH-1:0]               deq_valid;
  logic [$clog2(WIDTH+1)-1:0]     deq_take;
  logic [$clog2(DEPTH+1)-1:0]     count;

  modport master (
    output flush, enq_uop, enq_valid, deq_take,
    input  enq_ready, deq_uop, deq_valid, count
  );

  modport slave (
    input  flush, enq_uop, enq_valid, deq_take,
    output enq_ready, deq_uop, deq_valid, count
  );
endinterface

// File: rtl/rename_dispatch_queue_rdq_ptr_adv.sv
// Lane popcount and modulo-DEPTH pointer advance, shared by head and tail.
module rdq_ptr_adv #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic [$clog2(DEPTH)-1:0]   ptr_i,
  input  logic [WIDTH-1:0]           lanes_i,
  output logic [$clog2(WIDTH+1)-1:0] cnt_o,
  output logic [$clog2(DEPTH)-1:0]   ptr_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(WIDTH+1);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_o = cnt_o + TW'(lanes_i[i]);
    end
    // DEPTH is a power of two, so natural overflow is the modulo wrap.
    ptr_o = ptr_i + PW'(cnt_o);
  end
endmodule

// File: rtl/rename_dispatch_queue.sv
// Multi-lane in-order rename->dispatch circular queue.
// Define RD_QUEUE_PERF_EN to add the stall_cycles performance counter.
module rename_dispatch_queue
  import rename_dispatch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = RD_QUEUE_WIDTH,
  parameter int unsigned DEPTH = RD_QUEUE_DEPTH
) (
  input  logic clk,
  input  logic rst,
`ifdef RD_QUEUE_PERF_EN
  output logic [31:0] stall_cycles,
`endif
  rename_dispatch_queue_if.slave q
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned TW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] ENQ_LIMIT = CW'(DEPTH - WIDTH);

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]    head_adv, tail_adv;
  logic [CW-1:0]    count_q, count_d;
  logic [TW-1:0]    enq_cnt, deq_cnt;
  logic [WIDTH-1:0] enq_fire, take_lanes;
  logic             enq_ready_w;
  Disp_uOP          mem_q [DEPTH];

  // Ready depends on registered occupancy only; space freed by a same-cycle
  // take is not visible until the next cycle.
  assign enq_ready_w = (count_q <= ENQ_LIMIT);
  assign enq_fire    = q.enq_valid & {WIDTH{enq_ready_w}};

  always_comb begin
    take_lanes = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      take_lanes[i] = (TW'(i) < q.deq_take);
    end
  end

  rdq_ptr_adv #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tail_adv (
    .ptr_i   (tail_q),
    .lanes_i (enq_fire),
    .cnt_o   (enq_cnt),
    .ptr_o   (tail_adv)
  );

  rdq_ptr_adv #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_head_adv (
    .ptr_i   (head_q),
    .lanes_i (take_lanes),
    .cnt_o   (deq_cnt),
    .ptr_o   (head_adv)
  );

  always_comb begin
    head_d  = head_adv;
    tail_d  = tail_adv;
    count_d = count_q + CW'(enq_cnt) - CW'(deq_cnt);
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (enq_fire[i]) begin
        mem_q[tail_q + PW'(i)] <= q.enq_uop[i];
      end
    end
  end

  always_comb begin
    q.deq_valid = '0;
    q.deq_uop   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      q.deq_valid[i] = (count_q > CW'(i));
      q.deq_uop[i]   = mem_q[head_q + PW'(i)];
    end
  end

  assign q.enq_ready = enq_ready_w;
  assign q.count     = count_q;

`ifdef RD_QUEUE_PERF_EN
  logic [31:0] stall_q;

  // Survives flush on purpose: it measures rename back-pressure over time.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (q.enq_valid[0] && !enq_ready_w && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

`ifndef SYNTHESIS
  logic [TW-1:0] avail;
  assign avail = (count_q >= CW'(WIDTH)) ? TW'(WIDTH) : TW'(count_q);

  a_take_legal: assert property (@(posedge clk) disable iff (rst || q.flush)
    q.deq_take <= avail);
  a_enq_contig: assert property (@(posedge clk) disable iff (rst)
    lanes_contiguous(32'(q.enq_valid)));
`endif

endmodule
